shift_div_sched: RTL and testbench

- Round-robin scheduler that shares one combinational shift-divider datapath among NUM_REQ requesters.
- Datapath function: result = dividend >> amount, with an 8-bit dividend and a 3-bit amount.
- Accepts one request at a time over valid/ready, drives the datapath operands from registers, captures the result, and returns it tagged with the requester index over a valid/ready response port.
- Sits between client blocks and the shared divider instance.

---
 rtl/shift_div_sched.sv | 149 ++++++++++++++
 tb/tb_shift_div_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_div_sched.sv
// Round-robin scheduler sharing one shift-divider datapath (result = dividend >> amount).
// Optional result self-check is compiled in when SHIFT_DIV_SELFCHECK_EN is defined.
module shift_div_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_dividend,
    input  logic [NUM_REQ*3-1:0] req_divisor,
    output logic [7:0]           div_dividend,
    output logic [2:0]           div_divisor,
    input  logic [7:0]           div_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [IDX_W-1:0]     rsp_id,
    output logic                 busy,
    output logic                 err_sticky
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [7:0]       dvd_q, dvd_d;
    logic [2:0]       amt_q, amt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0] rsp_id_q, rsp_id_d;

    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    int unsigned      cand;

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Gated by rst so the grant vanishes the moment reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && gnt_found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        dvd_d       = dvd_q;
        amt_d       = amt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    dvd_d   = req_dividend[8*gnt_idx +: 8];
                    amt_d   = req_divisor[3*gnt_idx +: 3];
                    id_d    = gnt_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rsp_data_d  = div_result;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            dvd_q       <= '0;
            amt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            dvd_q       <= dvd_d;
            amt_q       <= amt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = amt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_id       = rsp_id_q;
    assign busy         = (state_q != StIdle);

`ifdef SHIFT_DIV_SELFCHECK_EN
    logic err_q, err_d;

    // Reference quotient is built from the operand registers, not from the requesters.
    always_comb begin
        err_d = err_q;
        if (state_q == StIssue && div_result != (dvd_q >> amt_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shift_div_sched.sv
// Scoreboard bench for shift_div_sched: driver pushes expected responses, monitor pops and compares.
module tb_shift_div_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_dividend;
    logic [11:0] req_divisor;
    logic [7:0]  div_dividend;
    logic [2:0]  div_divisor;
    logic [7:0]  div_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic        err_sticky;
    logic        corrupt;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    int         gnt_q[$];

`ifdef SHIFT_DIV_SELFCHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    shift_div_sched #(
        .NUM_REQ(4),
        .IDX_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dividend(req_dividend),
        .req_divisor (req_divisor),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_result  (div_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .busy        (busy),
        .err_sticky  (err_sticky)
    );

    // Stub datapath; corrupt flips bit 0 to provoke the self-check.
    assign div_result = (div_dividend >> div_divisor) ^ {7'b0, corrupt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed at the edge following a negedge with valid & ready.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {22'b0, rsp_id, rsp_data}, 32'h3ff);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", {30'b0, rsp_id}, {30'b0, e[9:8]});
                    check("rsp_data", {24'b0, rsp_data}, {24'b0, e[7:0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_opnd(input int i, input logic [7:0] d, input logic [2:0] a);
        req_dividend[i*8 +: 8] = d;
        req_divisor[i*3 +: 3]  = a;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Holds mask until n grants are seen; returns at grant edge + 1.
    task automatic grant_n(input logic [3:0] mask, input int n);
        int got    = 0;
        int waited = 0;
        int id;
        req_valid = mask;
        while (got < n && waited < 100) begin
            @(negedge clk);
            waited++;
            if (req_ready != 4'b0) begin
                got++;
                id = (gnt_q.size() != 0) ? gnt_q.pop_front() : 0;
                check("grant_onehot", {28'b0, req_ready}, 32'd1 << id);
            end
        end
        if (got < n) check("grant_timeout", got, n);
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        #1;
    endtask

    task automatic wait_rsp_valid();
        int waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(posedge clk);
            #1 waited++;
        end
        check("rsp_valid_seen", {31'b0, rsp_valid}, 1);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        corrupt      = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_req_ready", {28'b0, req_ready}, 0);
        check("rst_div_ops", {21'b0, div_dividend, div_divisor}, 0);
        check("rst_rsp_data_id", {22'b0, rsp_id, rsp_data}, 0);
        check("rst_err", {31'b0, err_sticky}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request: 200 >> 3 = 25.
        set_opnd(0, 8'd200, 3'd3);
        gnt_q.push_back(0);
        exp_q.push_back({2'd0, 8'd25});
        grant_n(4'b0001, 1);
        check("single_busy_issue", {31'b0, busy}, 1);
        check("single_ready_low", {28'b0, req_ready}, 0);
        check("single_valid_early", {31'b0, rsp_valid}, 0);
        @(posedge clk);
        #1;
        check("single_valid", {31'b0, rsp_valid}, 1);
        check("single_busy_resp", {31'b0, busy}, 1);
        @(posedge clk);
        #1;
        check("single_busy_done", {31'b0, busy}, 0);
        check("single_valid_done", {31'b0, rsp_valid}, 0);
        wait_drain();

        // Round robin from a fresh pointer: 0,1,2,3,0.
        do_reset();
        set_opnd(0, 8'd100, 3'd1);
        set_opnd(1, 8'd200, 3'd2);
        set_opnd(2, 8'd50, 3'd3);
        set_opnd(3, 8'd255, 3'd4);
        gnt_q = '{0, 1, 2, 3, 0};
        exp_q.push_back({2'd0, 8'd50});
        exp_q.push_back({2'd1, 8'd50});
        exp_q.push_back({2'd2, 8'd6});
        exp_q.push_back({2'd3, 8'd15});
        exp_q.push_back({2'd0, 8'd50});
        grant_n(4'b1111, 5);
        wait_drain();

        // Backpressure on requester 2 (0xFF >> 0), then requester 3 (0xFF >> 7).
        set_opnd(2, 8'hFF, 3'd0);
        set_opnd(3, 8'hFF, 3'd7);
        rsp_ready = 1'b0;
        gnt_q.push_back(2);
        exp_q.push_back({2'd2, 8'd255});
        grant_n(4'b0100, 1);
        wait_rsp_valid();
        req_valid = 4'b1000;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {31'b0, rsp_valid}, 1);
            check("bp_data", {24'b0, rsp_data}, 32'd255);
            check("bp_id", {30'b0, rsp_id}, 2);
            check("bp_ready", {28'b0, req_ready}, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        gnt_q.push_back(3);
        exp_q.push_back({2'd3, 8'd1});
        grant_n(4'b1000, 1);
        check("bp_valid_dropped", {31'b0, rsp_valid}, 0);
        wait_drain();

        // 0x80 >> 7 keeps only the top bit.
        set_opnd(1, 8'h80, 3'd7);
        gnt_q.push_back(1);
        exp_q.push_back({2'd1, 8'd1});
        grant_n(4'b0010, 1);
        wait_drain();

        // Asynchronous reset while a response is held: no response, pointer back to 0.
        set_opnd(0, 8'h10, 3'd0);
        rsp_ready = 1'b0;
        gnt_q.push_back(0);
        grant_n(4'b0001, 1);
        wait_rsp_valid();
        req_valid = 4'b0010;
        #2 rst = 1'b1;
        #1;
        check("arst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_req_ready", {28'b0, req_ready}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        gnt_q.push_back(0);
        exp_q.push_back({2'd0, 8'h10});
        grant_n(4'b1111, 1);
        wait_drain();

        // Faulty datapath result: 0xA5 >> 2 = 0x29, stub returns 0x28.
        check("err_clean", {31'b0, err_sticky}, 0);
        corrupt = 1'b1;
        set_opnd(3, 8'hA5, 3'd2);
        gnt_q.push_back(3);
        exp_q.push_back({2'd3, 8'h28});
        grant_n(4'b1000, 1);
        wait_drain();
        corrupt = 1'b0;
        check("err_set", {31'b0, err_sticky}, {31'b0, EXP_ERR});
        repeat (3) @(posedge clk);
        #1;
        check("err_held", {31'b0, err_sticky}, {31'b0, EXP_ERR});
        do_reset();
        check("err_cleared", {31'b0, err_sticky}, 0);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
